// File: rtl/instr_encoder.sv
// instr_encoder: streaming MIPS-subset instruction encoder for the program-load path.
// Each symbolic instruction beat (mnemonic select plus operand fields) is packed into a
// 32-bit instruction word. The word is emitted with a sequential byte address toward the
// instruction-memory write logic.
// Optional feature macro: INSTR_ENCODER_FPU_EN. When it is defined, op_sel 11..15 encode
// as FPU instructions. When it is undefined, those selects are rejected as illegal beats.
module instr_encoder #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [3:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       immediate,
  input  logic [25:0]       target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_word,
  output logic              done,
  output logic              err_illegal,
  output logic [ADDR_W-1:0] word_count
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pointer;
  logic              enc_legal;
  logic [31:0]       enc_word;
  logic              beat;
  logic              out_xfer;

  // Input is accepted only while loading, and only when the output register can take a word.
  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign beat     = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // Combinational packing of the current beat into the decoder's word format.
  always_comb begin
    enc_legal = 1'b1;
    enc_word  = 32'h0;
    case (op_sel)
      4'd0:  enc_word = {6'h23, rs, rt, immediate};          // LW
      4'd1:  enc_word = {6'h2B, rs, rt, immediate};          // SW
      4'd2:  enc_word = {6'h02, target};                     // J
      4'd3:  enc_word = {6'h03, target};                     // JAL
      4'd4:  enc_word = {6'h05, rs, rt, immediate};          // BNE
      4'd5:  enc_word = {6'h08, rs, rt, immediate};          // ADDI
      4'd6:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h0E};    // XORI (R-type form in this CPU)
      4'd7:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h20};    // ADD
      4'd8:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h22};    // SUB
      4'd9:  enc_word = {6'h00, rs, rt, rd, 5'b0, 6'h2A};    // SLT
      4'd10: enc_word = {6'h00, rs, 15'b0, 6'h08};           // JR: rt/rd ignored
`ifdef INSTR_ENCODER_FPU_EN
      4'd11: enc_word = {6'h11, rs, rt, rd, 5'b0, 6'h00};    // ADD.S
      4'd12: enc_word = {6'h11, rs, rt, rd, 5'b0, 6'h02};    // MUL.S
      4'd13: enc_word = {6'h11, rs, rt, rd, 5'b0, 6'h03};    // DIV.S
      4'd14: enc_word = {6'h11, rs, rt, rd, 5'b0, 6'h04};    // SQRT.S
      4'd15: enc_word = {6'h12, rs, rt, immediate};          // MULI.S
`else
      4'd11, 4'd12, 4'd13, 4'd14, 4'd15: enc_legal = 1'b0;   // FPU ops not built
`endif
      default: enc_legal = 1'b0;
    endcase
  end

  // Load-sequencing FSM with the output register, address pointer and status pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      pointer     <= '0;
      out_valid   <= 1'b0;
      out_word    <= 32'h0;
      out_addr    <= '0;
      done        <= 1'b0;
      err_illegal <= 1'b0;
      word_count  <= '0;
    end else begin
      done        <= 1'b0;
      err_illegal <= 1'b0;
      if (out_xfer) begin
        out_valid  <= 1'b0;
        word_count <= word_count + ADDR_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            pointer    <= {base_addr[ADDR_W-1:2], 2'b00};
            word_count <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          if (beat) begin
            if (enc_legal) begin
              out_valid <= 1'b1;
              out_word  <= enc_word;
              out_addr  <= pointer;
              pointer   <= pointer + ADDR_W'(4);
            end else begin
              err_illegal <= 1'b1;
            end
            if (in_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish once nothing is left in the output register after this edge.
          if (!out_valid || out_ready) begin
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
